// File: rtl/resonator_bank.sv
// Time-multiplexed bank of damped two-pole resonators kicked by level steps.
// Optional snap-to-zero of decayed channels: define RESONATOR_DEADBAND_EN.
module resonator_bank #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 4,
    parameter int OUT_W    = 16,
    parameter int FRAC     = 6,
    parameter logic [16*CHANNELS-1:0] A1_COEFS = {CHANNELS{16'sd127}},
    parameter logic [16*CHANNELS-1:0] A2_COEFS = {CHANNELS{16'sd63}},
    parameter int GAIN     = 1,
    parameter int DEADBAND = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en_48KHz,
    input  logic [CHANNELS*IN_W-1:0]  level,
    output logic [CHANNELS*OUT_W-1:0] ch_out,
    output logic [OUT_W-1:0]          mix_out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int PW = 2*OUT_W + 2;
    localparam int MW = OUT_W + 3;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [PW-1:0] GAIN_P  = PW'(GAIN);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [MW-1:0] MIX_MAX = {4'b0000, {(OUT_W-1){1'b1}}};
    localparam logic signed [MW-1:0] MIX_MIN = {4'b1111, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, UPD, OUT} state_t;

    state_t                     state_reg, state_next;
    logic [CW-1:0]              ch_reg;
    logic [CHANNELS*IN_W-1:0]   x_snap_reg;
    logic signed [OUT_W-1:0]    y1_reg [CHANNELS];
    logic signed [OUT_W-1:0]    y2_reg [CHANNELS];
    logic signed [OUT_W-1:0]    ch_out_reg [CHANNELS];
    logic [IN_W-1:0]            x_prev_reg [CHANNELS];
    logic signed [PW-1:0]       prod_a_reg, prod_b_reg;
    logic signed [MW-1:0]       mix_acc_reg;
    logic signed [OUT_W-1:0]    mix_out_reg;
    logic                       out_valid_reg, overrun_reg;

    logic signed [15:0]         a1_tab [CHANNELS];
    logic signed [15:0]         a2_tab [CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign a1_tab[gi] = A1_COEFS[16*gi +: 16];
            assign a2_tab[gi] = A2_COEFS[16*gi +: 16];
            assign ch_out[gi*OUT_W +: OUT_W] = ch_out_reg[gi];
        end
    endgenerate

    assign mix_out   = mix_out_reg;
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != IDLE);

    // Datapath for the channel currently addressed by ch_reg
    logic                    last_ch;
    logic signed [OUT_W-1:0] y1_cur, y2_cur, y_sat, y_wr, y2_wr;
    logic [IN_W-1:0]         x_cur, x_old;
    logic signed [IN_W:0]    step;
    logic signed [PW-1:0]    mul_x, mul_y, product, step_ext, sum;
    logic signed [MW-1:0]    mix_sum;
    logic signed [OUT_W-1:0] mix_sat;

    always_comb begin
        last_ch = (ch_reg == CW'(CHANNELS-1));
        y1_cur  = y1_reg[ch_reg];
        y2_cur  = y2_reg[ch_reg];
        x_cur   = x_snap_reg[ch_reg*IN_W +: IN_W];
        x_old   = x_prev_reg[ch_reg];

        // Single shared multiplier: a1*y1 in MUL_A, a2*y2 otherwise
        if (state_reg == MUL_A) begin
            mul_x = {{(PW-16){a1_tab[ch_reg][15]}}, a1_tab[ch_reg]};
            mul_y = {{(PW-OUT_W){y1_cur[OUT_W-1]}}, y1_cur};
        end else begin
            mul_x = {{(PW-16){a2_tab[ch_reg][15]}}, a2_tab[ch_reg]};
            mul_y = {{(PW-OUT_W){y2_cur[OUT_W-1]}}, y2_cur};
        end
        product = mul_x * mul_y;

        step     = {1'b0, x_old} - {1'b0, x_cur};
        step_ext = {{(PW-IN_W-1){step[IN_W]}}, step};
        sum      = ((prod_a_reg - prod_b_reg) >>> FRAC) + GAIN_P * step_ext;

        if (sum > SAT_MAX)
            y_sat = SAT_MAX[OUT_W-1:0];
        else if (sum < SAT_MIN)
            y_sat = SAT_MIN[OUT_W-1:0];
        else
            y_sat = sum[OUT_W-1:0];

        y_wr  = y_sat;
        y2_wr = y1_cur;
`ifdef RESONATOR_DEADBAND_EN
        if ((step == '0) &&
            (PW'(y_sat)  <= PW'(DEADBAND)) && (PW'(y_sat)  >= -PW'(DEADBAND)) &&
            (PW'(y1_cur) <= PW'(DEADBAND)) && (PW'(y1_cur) >= -PW'(DEADBAND))) begin
            y_wr  = '0;
            y2_wr = '0;
        end
`endif

        mix_sum = mix_acc_reg + {{3{y_wr[OUT_W-1]}}, y_wr};
        if (mix_sum > MIX_MAX)
            mix_sat = MIX_MAX[OUT_W-1:0];
        else if (mix_sum < MIX_MIN)
            mix_sat = MIX_MIN[OUT_W-1:0];
        else
            mix_sat = mix_sum[OUT_W-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (clk_en_48KHz) state_next = MUL_A;
            MUL_A:   state_next = MUL_B;
            MUL_B:   state_next = UPD;
            UPD:     state_next = last_ch ? OUT : MUL_A;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_reg        <= '0;
            x_snap_reg    <= '0;
            prod_a_reg    <= '0;
            prod_b_reg    <= '0;
            mix_acc_reg   <= '0;
            mix_out_reg   <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                y1_reg[i]     <= '0;
                y2_reg[i]     <= '0;
                x_prev_reg[i] <= '0;
                ch_out_reg[i] <= '0;
            end
        end else begin
            out_valid_reg <= 1'b0;
            if (clk_en_48KHz && state_reg != IDLE)
                overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (clk_en_48KHz) begin
                        x_snap_reg  <= level;
                        mix_acc_reg <= '0;
                        ch_reg      <= '0;
                    end
                end
                MUL_A: prod_a_reg <= product;
                MUL_B: prod_b_reg <= product;
                UPD: begin
                    y1_reg[ch_reg]     <= y_wr;
                    y2_reg[ch_reg]     <= y2_wr;
                    x_prev_reg[ch_reg] <= x_cur;
                    ch_out_reg[ch_reg] <= y_wr;
                    mix_acc_reg        <= mix_sum;
                    // Publish on the edge entering OUT so out_valid is high during OUT
                    if (last_ch) begin
                        mix_out_reg   <= mix_sat;
                        out_valid_reg <= 1'b1;
                    end else begin
                        ch_reg <= ch_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
